// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM word cache: controller states, the memory
// address width, and the tag width derived from it.
package psram_pkg;

  localparam int PSRAM_AW = 22;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    R_ISSUE,
    R_WAIT,
    W_ISSUE,
    W_WAIT
  } state_t;

  function automatic int tag_width(input int idx_w);
    return PSRAM_AW - idx_w;
  endfunction

endpackage

// File: rtl/psram_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// one synchronous write port, and a bulk clear of every valid bit.
module psram_cache_array
  import psram_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = tag_width(IDX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [31:0]      i_wr_data,
  input  logic             i_clr
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx];

endmodule

// File: rtl/psram_cache.sv
// Direct-mapped write-through, no-write-allocate word cache in front of the
// PSRAM memory controller, with read hit/miss counters.
module psram_cache
  import psram_pkg::*;
#(
  parameter  int LINES = 64,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PSRAM_AW-1:0] a,
  input  logic [31:0]         d,
  input  logic                we,
  input  logic                rd,
  output logic [31:0]         spo,
  output logic                ready,
  input  logic                inv,
  output logic [PSRAM_AW-1:0] mem_a,
  output logic [31:0]         mem_d,
  output logic                mem_we,
  output logic                mem_rd,
  input  logic [31:0]         mem_spo,
  input  logic                mem_ready,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int TAG_W = tag_width(IDX_W);

  state_t              r_state;
  state_t              w_next;
  logic [PSRAM_AW-1:0] r_a;
  logic [31:0]         r_d;
  logic [31:0]         r_spo;
  logic [31:0]         r_hit;
  logic [31:0]         r_miss;
  logic                r_ready;
  logic                r_skip;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_valid;
  logic [TAG_W-1:0]    w_tag_q;
  logic [31:0]         w_data_q;
  logic                w_hit;
  logic                w_fill;
  logic                w_wr_en;
  logic [31:0]         w_wr_data;
  logic                w_clr;

  assign w_idx     = r_a[IDX_W-1:0];
  assign w_tag     = r_a[PSRAM_AW-1:IDX_W];
  assign w_hit     = w_valid && (w_tag_q == w_tag);
  assign w_fill    = (r_state == R_WAIT) && !r_skip && mem_ready;
  // Write hits refresh the line in place; a write miss leaves the line alone.
  assign w_wr_en   = w_fill || ((r_state == W_ISSUE) && w_hit);
  assign w_wr_data = (r_state == R_WAIT) ? mem_spo : r_d;
  assign w_clr     = (r_state == IDLE) && inv && !rd && !we;

  psram_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_rd_idx  (w_idx),
    .o_valid   (w_valid),
    .o_tag     (w_tag_q),
    .o_data    (w_data_q),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_idx),
    .i_wr_tag  (w_tag),
    .i_wr_data (w_wr_data),
    .i_clr     (w_clr)
  );

  always_comb begin
    w_next = r_state;
    mem_rd = 1'b0;
    mem_we = 1'b0;
    case (r_state)
      IDLE: begin
        if (we)      w_next = W_ISSUE;
        else if (rd) w_next = LOOKUP;
      end
      LOOKUP:  w_next = w_hit ? IDLE : R_ISSUE;
      R_ISSUE: begin
        if (mem_ready) begin
          mem_rd = 1'b1;
          w_next = R_WAIT;
        end
      end
      R_WAIT:  if (!r_skip && mem_ready) w_next = IDLE;
      W_ISSUE: begin
        if (mem_ready) begin
          mem_we = 1'b1;
          w_next = W_WAIT;
        end
      end
      W_WAIT:  if (!r_skip && mem_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_d     <= '0;
      r_spo   <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
      r_ready <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_a <= a;
          r_d <= d;
          if (rd || we)  r_ready <= 1'b0;
          else if (!inv) r_ready <= mem_ready;
        end
        LOOKUP: begin
          if (w_hit) begin
            r_spo   <= w_data_q;
            r_hit   <= r_hit + 32'd1;
            r_ready <= 1'b1;
          end else begin
            r_miss  <= r_miss + 32'd1;
          end
        end
        // The controller's ready lags our issue pulse by one clock; ignore it once.
        R_ISSUE, W_ISSUE: r_skip <= 1'b1;
        R_WAIT: begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (mem_ready) begin
            r_spo   <= mem_spo;
            r_ready <= 1'b1;
          end
        end
        W_WAIT: begin
          if (r_skip)         r_skip  <= 1'b0;
          else if (mem_ready) r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign spo        = r_spo;
  assign ready      = r_ready & ~(rd | we);
  assign mem_a      = r_a;
  assign mem_d      = r_d;
  assign hit_count  = r_hit;
  assign miss_count = r_miss;

  a_req_only_idle: assert property (@(posedge clk) disable iff (rst)
    (r_state != IDLE) |-> !(rd || we))
    else $error("psram_cache: rd/we while busy");

  a_mem_pulse_excl: assert property (@(posedge clk) disable iff (rst)
    !(mem_rd && mem_we));

endmodule

// File: doc/psram_cache.md
Name: psram_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache.
- Sits between the CPU data bus and memory_controller; hides the multi-microsecond PSRAM read latency on hits.
- CPU-side handshake is identical to memory_controller's, so the cache drops in transparently.
- Exposes hit/miss counters for performance monitoring.

Parameters:
- LINES, 64, number of one-word lines; power of two, 2..1024.
- IDX_W, $clog2(LINES), index width; derived, never overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- a  input  22  CPU word address.
- d  input  32  CPU write data.
- we  input  1  CPU write request, one-cycle pulse.
- rd  input  1  CPU read request, one-cycle pulse.
- spo  output  32  read data; valid while ready=1 after a read.
- ready  output  1  idle/done flag; equals ready_r & !(rd|we).
- inv  input  1  invalidate-all pulse; honoured only in IDLE.
- mem_a  output  22  word address to memory_controller.
- mem_d  output  32  write data to memory_controller.
- mem_we  output  1  write pulse to memory_controller.
- mem_rd  output  1  read pulse to memory_controller.
- mem_spo  input  32  read data from memory_controller.
- mem_ready  input  1  memory_controller ready.
- hit_count  output  32  read hits since reset.
- miss_count  output  32  read misses since reset.

Behaviour:
- Reset (synchronous, active-high, one clk): state=IDLE; all valid bits cleared; mem_rd=mem_we=0; ready_r=0; spo=0; hit_count=miss_count=0. Tag and data arrays are not reset.
- Address split: index=a[IDX_W-1:0]; tag=a[21:IDX_W] (16 bits at the default).
- Storage: valid bits in a LINES-bit register; tag and data arrays are read combinationally, written synchronously.
- IDLE:
  - Latch a and d every cycle.
  - Request priority: we > rd > inv; simultaneous rd and we is treated as a write.
  - we: ready_r<=0, go W_ISSUE.
  - rd: ready_r<=0, go LOOKUP.
  - inv (no rd/we): clear all valid bits in that cycle; ready_r unchanged.
  - No request: ready_r<=mem_ready.
- LOOKUP: hit = valid[idx] & (tag_arr[idx]==tag).
  - Hit: spo<=data_arr[idx], hit_count+1, ready_r<=1, go IDLE. ready rises 2 clks after the rd pulse.
  - Miss: miss_count+1, go R_ISSUE.
- R_ISSUE: wait for mem_ready=1; then assert mem_rd for exactly one clk with mem_a=latched address; go R_WAIT.
- R_WAIT:
  - Skip the first cycle after issue: memory_controller's ready_r lags one clk.
  - Then wait for mem_ready=1.
  - On mem_ready=1: data_arr[idx]<=mem_spo, tag_arr[idx]<=tag, valid[idx]<=1, spo<=mem_spo, ready_r<=1, go IDLE.
- W_ISSUE:
  - If the address hits, update data_arr[idx] with the latched d (write-through update). A miss does not allocate.
  - Wait for mem_ready=1; then pulse mem_we for one clk with mem_a and mem_d; go W_WAIT.
- W_WAIT: same one-cycle skip as R_WAIT, then wait for mem_ready=1; then ready_r<=1, go IDLE.
- Memory outputs: mem_rd and mem_we are never high together and never high for more than one clk. mem_a and mem_d hold stable from issue until the operation completes.
- Counters: writes do not count. Counters wrap 0xFFFFFFFF→0 silently.
- inv outside IDLE is ignored and not queued.
- rd/we outside IDLE is ignored; it is a protocol violation and is asserted in simulation only.
- rst mid-operation aborts immediately. A memory_controller operation already launched is left to finish; the next issue waits on mem_ready, so the two stay coherent.
- Aliasing: two addresses with equal index and different tags evict each other; no stale data is ever returned.

Decomposition:
- Shared package psram_pkg:
  - State encodings: IDLE, LOOKUP, R_ISSUE, R_WAIT, W_ISSUE, W_WAIT.
  - Constant PSRAM_AW=22.
  - Function computing tag width from IDX_W.
- One sub-module psram_cache_array: valid/tag/data storage with combinational read, synchronous single write port, and a bulk valid-clear input.
- The FSM and counters stay in psram_cache.

Test Plan:
- Cold read a=0x000040:
  - Expect one mem_rd pulse and miss_count=1.
  - Memory model returns 0xDEADBEEF; spo=0xDEADBEEF with ready.
  - Second rd of 0x000040 → no mem_rd, spo=0xDEADBEEF, ready exactly 2 clks after the rd pulse, hit_count=1.
- Alias eviction: read 0x000005, then 0x000045, then 0x000005 → three mem_rd pulses, miss_count=3, each spo matches the model.
- Write hit then read: rd 0x000010 (fill); we 0x000010 d=0x12345678 → one mem_we pulse with mem_d=0x12345678. Following rd → no mem_rd, spo=0x12345678.
- Write miss: we 0x0000AA on an invalid line → mem_we pulse, no allocation. Subsequent rd → mem_rd issued, miss_count increments.
- inv: fill 4 lines, pulse inv in IDLE, re-read all 4 → 4 mem_rd pulses. inv pulsed during R_WAIT → ignored; the filled line still hits afterwards.
- Reset and priority:
  - rst asserted in R_WAIT → next cycle state IDLE, mem_rd=0, counters 0, prior hits now miss.
  - Simultaneous rd and we → a single mem_we pulse, no mem_rd.
